// File: rtl/des_nic_output_block.sv
// Transmit stage of the DES NIC: captures engine result, key and header, then sends a
// 5-flit packet under link credit flow control. Optional sticky error flag: DES_NIC_OUTPUT_ERROR_EN.
module des_nic_output_block #(
  parameter int CHANNEL_WIDTH = 32,
  parameter int DATA_FLITS    = 4,
  parameter int BUFFER_DEPTH  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [63:0]              ciphertext_din,
  input  logic [63:0]              key_din,
  input  logic [CHANNEL_WIDTH-3:0] header_flit_din,
  input  logic                     done_strobe_din,
  input  logic                     credit_in_din,
  output logic [CHANNEL_WIDTH-1:0] output_channel_dout,
  output logic                     zero_credits_dout,
`ifdef DES_NIC_OUTPUT_ERROR_EN
  output logic                     error_dout,
`endif
  output logic                     busy_dout
);

  localparam int PACKET_FLITS = DATA_FLITS + 1;
  localparam int DATA_W       = DATA_FLITS * CHANNEL_WIDTH;
  localparam int HDR_W        = CHANNEL_WIDTH - 2;
  localparam int CNT_W        = $clog2(BUFFER_DEPTH + 1);
  localparam int FLIT_W       = $clog2(PACKET_FLITS);

  localparam logic [CNT_W-1:0]  PKT_CNT   = CNT_W'(PACKET_FLITS);
  localparam logic [CNT_W-1:0]  BUF_CNT   = CNT_W'(BUFFER_DEPTH);
  localparam logic [FLIT_W-1:0] LAST_FLIT = FLIT_W'(PACKET_FLITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t                   state_r, state_next_s;
  logic [FLIT_W-1:0]        flit_r, flit_next_s;
  logic [CNT_W-1:0]         credit_r;
  logic [DATA_W-1:0]        hold_data_r;
  logic [HDR_W-1:0]         hold_hdr_r;
  logic [DATA_W-1:0]        data_in_s;
  logic [HDR_W-1:0]         hdr_src_s;
  logic [CHANNEL_WIDTH-1:0] out_r, out_next_s;
  logic                     busy_r, busy_next_s;
  logic                     accept_s;
  logic                     credits_ok_s;
  logic                     credit_dec_s;

  // Flit 0 is the header with the valid and processed flags set; flits 1.. are raw data words, MSW first.
  function automatic logic [CHANNEL_WIDTH-1:0] flit_sel(
    input logic [FLIT_W-1:0] idx,
    input logic [DATA_W-1:0] data,
    input logic [HDR_W-1:0]  hdr
  );
    logic [CHANNEL_WIDTH-1:0] f;
    f = {CHANNEL_WIDTH{1'b0}};
    if (idx == {FLIT_W{1'b0}}) begin
      f = {2'b11, hdr};
    end else begin
      for (int i = 0; i < DATA_FLITS; i++) begin
        if (idx == FLIT_W'(i + 1)) begin
          f = data[DATA_W-1-i*CHANNEL_WIDTH -: CHANNEL_WIDTH];
        end else begin
          f = f;
        end
      end
    end
    return f;
  endfunction

  assign data_in_s    = {ciphertext_din, key_din};
  assign accept_s     = done_strobe_din & ~busy_r;
  assign credits_ok_s = (credit_r >= PKT_CNT);
  assign credit_dec_s = (state_r == ST_SEND);

  // FSM state and flit counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      flit_r  <= {FLIT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      flit_r  <= flit_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    flit_next_s  = flit_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = credits_ok_s ? ST_SEND : ST_WAIT;
          flit_next_s  = {FLIT_W{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (credits_ok_s) begin
          state_next_s = ST_SEND;
          flit_next_s  = {FLIT_W{1'b0}};
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_SEND: begin
        if (flit_r == LAST_FLIT) begin
          state_next_s = ST_IDLE;
          flit_next_s  = {FLIT_W{1'b0}};
        end else begin
          flit_next_s  = flit_r + {{(FLIT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        flit_next_s  = {FLIT_W{1'b0}};
      end
    endcase
  end

  // Output logic: the header of a packet launched straight from IDLE comes from the inputs,
  // because the holding register only loads on that same edge.
  always_comb begin
    out_next_s  = {CHANNEL_WIDTH{1'b0}};
    busy_next_s = (state_next_s != ST_IDLE);
    hdr_src_s   = hold_hdr_r;
    if (state_r == ST_IDLE) begin
      hdr_src_s = header_flit_din;
    end else begin
      hdr_src_s = hold_hdr_r;
    end
    case (state_next_s)
      ST_SEND: out_next_s = flit_sel(flit_next_s, hold_data_r, hdr_src_s);
      default: out_next_s = {CHANNEL_WIDTH{1'b0}};
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r  <= {CHANNEL_WIDTH{1'b0}};
      busy_r <= 1'b0;
    end else begin
      out_r  <= out_next_s;
      busy_r <= busy_next_s;
    end
  end

  // Holding register: captures one packet per accepted strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data_r <= {DATA_W{1'b0}};
      hold_hdr_r  <= {HDR_W{1'b0}};
    end else if (accept_s) begin
      hold_data_r <= data_in_s;
      hold_hdr_r  <= header_flit_din;
    end else begin
      hold_data_r <= hold_data_r;
      hold_hdr_r  <= hold_hdr_r;
    end
  end

  // Credit counter: simultaneous return and send cancel; returns saturate at the buffer depth
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_r <= BUF_CNT;
    end else if (credit_in_din && !credit_dec_s) begin
      credit_r <= (credit_r == BUF_CNT) ? credit_r : credit_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!credit_in_din && credit_dec_s) begin
      credit_r <= (credit_r == {CNT_W{1'b0}}) ? credit_r : credit_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      credit_r <= credit_r;
    end
  end

`ifdef DES_NIC_OUTPUT_ERROR_EN
  logic error_r;

  // Sticky protocol error: credit overflow or strobe while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_r <= 1'b0;
    end else if ((credit_in_din && (credit_r == BUF_CNT)) || (done_strobe_din && busy_r)) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign error_dout = error_r;
`endif

  assign output_channel_dout = out_r;
  assign busy_dout           = busy_r;
  assign zero_credits_dout   = (credit_r < PKT_CNT);

endmodule

// File: doc/des_nic_output_block.md
Name: des_nic_output_block

Overview:
- Transmit stage of the DES network interface. It sits directly downstream of the DES processing engine and beside the NIC input block.
- It captures the engine's 64-bit result, the echoed key and the 30-bit header on a done strobe, and serialises them as a 5-flit packet onto the router output channel.
- Link-level credit flow control governs transmission. The block exports zero_credits_dout, which the input block uses to decide when to start the engine.

Parameters:
- CHANNEL_WIDTH, 32, flit width in bits.
- DATA_FLITS, 4, data flits per packet. Packet length PACKET_FLITS = DATA_FLITS+1 = 5.
- BUFFER_DEPTH, 5, downstream buffer slots. This is the credit counter reset value and its ceiling; must be >= PACKET_FLITS.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ciphertext_din  in  64  engine result, valid in the done_strobe_din cycle.
- key_din  in  64  key echoed from the input block, valid in the done_strobe_din cycle.
- header_flit_din  in  30  header bits [29:0], valid in the done_strobe_din cycle.
- done_strobe_din  in  1  one-cycle pulse: engine result ready.
- credit_in_din  in  1  one-cycle pulse: downstream freed one buffer slot.
- output_channel_dout  out  32  flit to router; all-zero when idle.
- zero_credits_dout  out  1  high when credit count < PACKET_FLITS.
- busy_dout  out  1  high while the holding register is occupied.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, credit count=BUFFER_DEPTH, flit counter=0.
  - output_channel_dout=0, busy_dout=0, zero_credits_dout=0, holding register cleared.
  - Reset asserted mid-packet aborts the packet immediately; no resume.
- Holding register: 128 data bits plus 30 header bits. It loads on done_strobe_din & !busy_dout.
- done_strobe_din while busy_dout=1 is ignored; the held packet is unchanged.
- FSM states:
  - IDLE: on an accepted strobe, go to SEND if credits >= PACKET_FLITS, else WAIT. busy_dout rises the cycle after the strobe.
  - WAIT: output zero. Move to SEND in the cycle after credits reach PACKET_FLITS.
  - SEND: drives one flit per cycle. Flit counter runs 0..4 and on flit 4 the block returns to IDLE. busy_dout drops the cycle after flit 4. A new strobe is accepted in that cycle.
- Flit order (registered output):
  - f0 = {1'b1, 1'b1, header[29:0]}: header bit 31 set, processed flag bit 30 forced to 1.
  - f1 = ciphertext[63:32], f2 = ciphertext[31:0], f3 = key[63:32], f4 = key[31:0].
  - Data flits are driven raw.
- Latency: with credits available, a strobe in cycle t puts the header on the output in cycle t+1 and f4 in cycle t+5. Back-to-back packets: next header no earlier than t+7.
- Credits:
  - Each SEND cycle decrements by 1; each credit_in_din pulse increments by 1.
  - Both in the same cycle: count unchanged.
  - Increment at BUFFER_DEPTH saturates, no wrap.
  - Count never underflows, because SEND starts only with >= PACKET_FLITS credits.
- zero_credits_dout is combinational from the credit register: (count < PACKET_FLITS). It therefore rises during SEND and falls when enough credits return.
- Counter width: $clog2(BUFFER_DEPTH+1) bits.

Optional Feature:
- Macro: DES_NIC_OUTPUT_ERROR_EN.
- When defined:
  - Adds output error_dout (1 bit), a sticky flag that sets on either a credit_in_din pulse at count=BUFFER_DEPTH or done_strobe_din while busy_dout=1.
  - It clears only on reset and is driven from a register.
- When undefined: the port and its logic are absent; both events are silently ignored as above.

Test Plan:
- Reset, then strobe with header=30'h0000_1234, ct=64'h0123456789ABCDEF, key=64'h133457799BBCDFF1 → output sequence C000_1234, 0123_4567, 89AB_CDEF, 1334_5779, 9BBC_DFF1 in cycles t+1..t+5. zero_credits_dout rises at the first SEND decrement and stays high. busy_dout falls at t+6.
- Continuing, pulse credit_in_din 5 times, then strobe again → output stays 0 until the 5th credit. Header appears 2 cycles after the 5th credit pulse (WAIT→SEND, then registered output). zero_credits_dout falls after the 5th pulse.
- Strobe while busy with a different ct=64'hFFFF... → transmitted flits are still from the first packet. With DES_NIC_OUTPUT_ERROR_EN, error_dout=1 from the next cycle.
- At count=5, pulse credit_in_din → count stays 5. With the macro, error_dout sets.
- During SEND, a credit_in_din pulse coincides with a flit → count unchanged that cycle. Final count equals 5 - 5 + pulses.
- Deassert-assert reset during flit f2 → output_channel_dout=0 immediately, busy_dout=0, zero_credits_dout=0. The next strobe sends a full 5-flit packet.
